// File: rtl/i2c_pkg.sv
// ---------------------------------------------------------------------------
// i2c_pkg
// Shared definitions for the system-clock-synchronous I2C slave:
//   - protocol FSM state encoding
//   - default 7-bit device address
//   - position of the R/W bit in the address byte
//   - fill byte sent when the transmit side has no data
// No ports.
// ---------------------------------------------------------------------------
package i2c_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ADDR     = 3'd1,
    ST_ADDR_ACK = 3'd2,
    ST_WR       = 3'd3,
    ST_WR_ACK   = 3'd4,
    ST_RD       = 3'd5,
    ST_RD_ACK   = 3'd6,
    ST_WAIT     = 3'd7
  } i2c_state_e;

  localparam logic [6:0] I2C_DEV_ADDR_DEF = 7'h47;
  localparam int         I2C_RW_BIT       = 0;
  localparam logic [7:0] I2C_NACK_FILL    = 8'hFF;
  localparam logic [3:0] I2C_BITS_PER_BYTE = 4'd8;

endpackage

// File: rtl/i2c_line_filter.sv
// ---------------------------------------------------------------------------
// i2c_line_filter
// Synchroniser + glitch filter + edge flags for one I2C line.
// The filtered value follows the synchronised input only after FILTER_LEN
// consecutive identical samples that differ from the current filtered value.
// Edge flags are single-cycle pulses registered together with the filtered
// value, so input-to-flag latency is SYNC_STAGES + FILTER_LEN cycles.
//
// Ports:
//   i_clk    in   system clock
//   i_rst_n  in   synchronous active-low reset (line resets to 1 = idle)
//   i_line   in   raw pad input
//   o_line   out  filtered line level
//   o_rise   out  one-cycle pulse on filtered 0->1
//   o_fall   out  one-cycle pulse on filtered 1->0
// ---------------------------------------------------------------------------
module i2c_line_filter #(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 3
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_line,
  output logic o_line,
  output logic o_rise,
  output logic o_fall
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [3:0]             r_cnt;
  logic                   r_line;
  logic                   r_rise;
  logic                   r_fall;
  logic                   w_sample;

  assign w_sample = r_sync[SYNC_STAGES-1];

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_sync <= '1;
      r_cnt  <= '0;
      r_line <= 1'b1;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_line};
      r_rise <= 1'b0;
      r_fall <= 1'b0;
      if (w_sample == r_line) begin
        r_cnt <= '0;
      end else if (r_cnt == 4'(FILTER_LEN - 1)) begin
        // FILTER_LEN-th consecutive differing sample: accept the change
        r_line <= w_sample;
        r_cnt  <= '0;
        r_rise <= w_sample;
        r_fall <= ~w_sample;
      end else begin
        r_cnt <= r_cnt + 4'd1;
      end
    end
  end

  assign o_line = r_line;
  assign o_rise = r_rise;
  assign o_fall = r_fall;

endmodule

// File: rtl/i2c_slave_sync.sv
// ---------------------------------------------------------------------------
// i2c_slave_sync
// System-clock-synchronous I2C slave with 7-bit address match, master-write
// byte stream (o_rx_*) and master-read byte stream (i_tx_* / o_tx_ready).
// SDA and SCL are filtered by i2c_line_filter; all drive outputs registered.
//
// Optional feature macro: I2C_SLAVE_CLK_STRETCH_EN
//   defined   : SCL is stretched while the RX sink is not ready at the ACK
//               decision, or while no TX byte is available at a TX load.
//   undefined : o_SCL_OE stays 0; RX overflow is NACKed (o_rx_ovf) and TX
//               underrun sends 0xFF (o_tx_underrun).
//
// Ports:
//   i_CLK, i_RST_N          system clock, synchronous active-low reset
//   i_SCL, i_SDA            raw pad inputs
//   o_SDA_OE, o_SCL_OE      open-drain pull-low enables
//   o_rx_data/valid, i_rx_ready, o_rx_ovf        master-write byte stream
//   i_tx_data/valid, o_tx_ready, o_tx_underrun   master-read byte stream
//   o_start, o_stop         START/repeated START, STOP strobes
//   o_busy                  addressed, from match until STOP / repeated START
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | bus free, waiting for START
// ADDR     | shifting in address + R/W
// ADDR_ACK | driving address ACK
// WR       | shifting in a write byte
// WR_ACK   | ACK/NACK slot after a write byte
// RD       | shifting out a read byte
// RD_ACK   | sampling the master's ACK/NACK
// WAIT     | not addressed or master NACKed: passive until START/STOP
// ---------------------------------------------------------------------------
module i2c_slave_sync
  import i2c_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR    = I2C_DEV_ADDR_DEF,
  parameter int         SYNC_STAGES = 2,
  parameter int         FILTER_LEN  = 3
) (
  input  logic       i_CLK,
  input  logic       i_RST_N,
  input  logic       i_SCL,
  input  logic       i_SDA,
  output logic       o_SDA_OE,
  output logic       o_SCL_OE,
  output logic [7:0] o_rx_data,
  output logic       o_rx_valid,
  input  logic       i_rx_ready,
  output logic       o_rx_ovf,
  input  logic [7:0] i_tx_data,
  input  logic       i_tx_valid,
  output logic       o_tx_ready,
  output logic       o_tx_underrun,
  output logic       o_start,
  output logic       o_stop,
  output logic       o_busy
);

`ifdef I2C_SLAVE_CLK_STRETCH_EN
  localparam logic STRETCH_EN = 1'b1;
`else
  localparam logic STRETCH_EN = 1'b0;
`endif

  logic w_scl, w_scl_rise, w_scl_fall;
  logic w_sda, w_sda_rise, w_sda_fall;
  logic w_start_cond, w_stop_cond;

  i2c_line_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_scl_filt (
    .i_clk   (i_CLK),
    .i_rst_n (i_RST_N),
    .i_line  (i_SCL),
    .o_line  (w_scl),
    .o_rise  (w_scl_rise),
    .o_fall  (w_scl_fall)
  );

  i2c_line_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_sda_filt (
    .i_clk   (i_CLK),
    .i_rst_n (i_RST_N),
    .i_line  (i_SDA),
    .o_line  (w_sda),
    .o_rise  (w_sda_rise),
    .o_fall  (w_sda_fall)
  );

  assign w_start_cond = w_sda_fall & w_scl;
  assign w_stop_cond  = w_sda_rise & w_scl;

  i2c_state_e r_state, w_state_nxt;
  logic [7:0] r_shift, w_shift_nxt;
  logic [3:0] r_bcnt, w_bcnt_nxt;
  logic       r_rw, w_rw_nxt;
  logic       r_sda_oe, w_sda_oe_nxt;
  logic       r_scl_oe, w_scl_oe_nxt;
  logic       r_busy, w_busy_nxt;
  logic [7:0] r_rx_data, w_rx_data_nxt;
  logic       r_rx_valid, w_rx_valid_nxt;
  logic       r_rx_ovf, w_rx_ovf_nxt;
  logic       r_tx_ready, w_tx_ready_nxt;
  logic       r_tx_underrun, w_tx_underrun_nxt;
  logic       r_start, w_start_nxt;
  logic       r_stop, w_stop_nxt;
  logic       r_hold_rx, w_hold_rx_nxt;
  logic       r_hold_tx, w_hold_tx_nxt;
  logic       w_tx_load;

  always_ff @(posedge i_CLK) begin
    if (!i_RST_N) begin
      r_state       <= ST_IDLE;
      r_shift       <= '0;
      r_bcnt        <= '0;
      r_rw          <= 1'b0;
      r_sda_oe      <= 1'b0;
      r_scl_oe      <= 1'b0;
      r_busy        <= 1'b0;
      r_rx_data     <= '0;
      r_rx_valid    <= 1'b0;
      r_rx_ovf      <= 1'b0;
      r_tx_ready    <= 1'b0;
      r_tx_underrun <= 1'b0;
      r_start       <= 1'b0;
      r_stop        <= 1'b0;
      r_hold_rx     <= 1'b0;
      r_hold_tx     <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_shift       <= w_shift_nxt;
      r_bcnt        <= w_bcnt_nxt;
      r_rw          <= w_rw_nxt;
      r_sda_oe      <= w_sda_oe_nxt;
      r_scl_oe      <= w_scl_oe_nxt;
      r_busy        <= w_busy_nxt;
      r_rx_data     <= w_rx_data_nxt;
      r_rx_valid    <= w_rx_valid_nxt;
      r_rx_ovf      <= w_rx_ovf_nxt;
      r_tx_ready    <= w_tx_ready_nxt;
      r_tx_underrun <= w_tx_underrun_nxt;
      r_start       <= w_start_nxt;
      r_stop        <= w_stop_nxt;
      r_hold_rx     <= w_hold_rx_nxt;
      r_hold_tx     <= w_hold_tx_nxt;
    end
  end

  always_comb begin
    w_state_nxt       = r_state;
    w_shift_nxt       = r_shift;
    w_bcnt_nxt        = r_bcnt;
    w_rw_nxt          = r_rw;
    w_sda_oe_nxt      = r_sda_oe;
    w_scl_oe_nxt      = r_scl_oe;
    w_busy_nxt        = r_busy;
    w_rx_data_nxt     = r_rx_data;
    w_rx_valid_nxt    = 1'b0;
    w_rx_ovf_nxt      = 1'b0;
    w_tx_ready_nxt    = 1'b0;
    w_tx_underrun_nxt = 1'b0;
    w_start_nxt       = 1'b0;
    w_stop_nxt        = 1'b0;
    w_hold_rx_nxt     = r_hold_rx;
    w_hold_tx_nxt     = r_hold_tx;
    w_tx_load         = 1'b0;

    // START/STOP take priority over any bit activity and any stretch
    if (w_start_cond) begin
      w_state_nxt   = ST_ADDR;
      w_bcnt_nxt    = '0;
      w_sda_oe_nxt  = 1'b0;
      w_scl_oe_nxt  = 1'b0;
      w_busy_nxt    = 1'b0;
      w_hold_rx_nxt = 1'b0;
      w_hold_tx_nxt = 1'b0;
      w_start_nxt   = 1'b1;
    end else if (w_stop_cond) begin
      w_state_nxt   = ST_IDLE;
      w_bcnt_nxt    = '0;
      w_sda_oe_nxt  = 1'b0;
      w_scl_oe_nxt  = 1'b0;
      w_busy_nxt    = 1'b0;
      w_hold_rx_nxt = 1'b0;
      w_hold_tx_nxt = 1'b0;
      w_stop_nxt    = 1'b1;
    end else if (r_hold_rx) begin
      if (i_rx_ready) begin
        w_rx_data_nxt  = r_shift;
        w_rx_valid_nxt = 1'b1;
        w_sda_oe_nxt   = 1'b1;
        w_state_nxt    = ST_WR_ACK;
        w_scl_oe_nxt   = 1'b0;
        w_hold_rx_nxt  = 1'b0;
      end
    end else if (r_hold_tx) begin
      if (i_tx_valid) begin
        w_tx_load = 1'b1;
      end
    end else begin
      case (r_state)
        ST_IDLE: ;
        ST_ADDR: begin
          if (w_scl_rise) begin
            w_shift_nxt = {r_shift[6:0], w_sda};
            w_bcnt_nxt  = r_bcnt + 4'd1;
          end else if (w_scl_fall && r_bcnt == I2C_BITS_PER_BYTE) begin
            w_bcnt_nxt = '0;
            w_rw_nxt   = r_shift[I2C_RW_BIT];
            if (r_shift[7:1] == DEV_ADDR) begin
              w_state_nxt  = ST_ADDR_ACK;
              w_sda_oe_nxt = 1'b1;
              w_busy_nxt   = 1'b1;
            end else begin
              w_state_nxt = ST_WAIT;
            end
          end
        end
        ST_ADDR_ACK: begin
          if (w_scl_fall) begin
            w_sda_oe_nxt = 1'b0;
            if (r_rw) begin
              w_tx_load = 1'b1;
            end else begin
              w_state_nxt = ST_WR;
            end
          end
        end
        ST_WR: begin
          if (w_scl_rise) begin
            w_shift_nxt = {r_shift[6:0], w_sda};
            w_bcnt_nxt  = r_bcnt + 4'd1;
          end else if (w_scl_fall && r_bcnt == I2C_BITS_PER_BYTE) begin
            w_bcnt_nxt = '0;
            if (i_rx_ready) begin
              w_rx_data_nxt  = r_shift;
              w_rx_valid_nxt = 1'b1;
              w_sda_oe_nxt   = 1'b1;
              w_state_nxt    = ST_WR_ACK;
            end else if (STRETCH_EN) begin
              w_hold_rx_nxt = 1'b1;
              w_scl_oe_nxt  = 1'b1;
            end else begin
              w_rx_ovf_nxt = 1'b1;
              w_state_nxt  = ST_WR_ACK;
            end
          end
        end
        ST_WR_ACK: begin
          if (w_scl_fall) begin
            w_sda_oe_nxt = 1'b0;
            w_state_nxt  = ST_WR;
          end
        end
        ST_RD: begin
          if (w_scl_fall) begin
            if (r_bcnt == 4'd7) begin
              w_sda_oe_nxt = 1'b0;
              w_bcnt_nxt   = '0;
              w_state_nxt  = ST_RD_ACK;
            end else begin
              w_shift_nxt  = {r_shift[6:0], 1'b0};
              w_sda_oe_nxt = ~r_shift[6];
              w_bcnt_nxt   = r_bcnt + 4'd1;
            end
          end
        end
        ST_RD_ACK: begin
          if (w_scl_rise) begin
            if (w_sda) begin
              w_state_nxt = ST_WAIT;
            end
          end else if (w_scl_fall) begin
            w_tx_load = 1'b1;
          end
        end
        ST_WAIT: ;
        default: w_state_nxt = ST_IDLE;
      endcase
    end

    if (w_tx_load) begin
      if (i_tx_valid) begin
        w_shift_nxt    = i_tx_data;
        w_sda_oe_nxt   = ~i_tx_data[7];
        w_tx_ready_nxt = 1'b1;
        w_state_nxt    = ST_RD;
        w_bcnt_nxt     = '0;
        w_hold_tx_nxt  = 1'b0;
        w_scl_oe_nxt   = 1'b0;
      end else if (STRETCH_EN) begin
        w_hold_tx_nxt = 1'b1;
        w_scl_oe_nxt  = 1'b1;
      end else begin
        w_shift_nxt       = I2C_NACK_FILL;
        w_sda_oe_nxt      = ~I2C_NACK_FILL[7];
        w_tx_underrun_nxt = 1'b1;
        w_state_nxt       = ST_RD;
        w_bcnt_nxt        = '0;
      end
    end
  end

  assign o_SDA_OE      = r_sda_oe;
  assign o_SCL_OE      = r_scl_oe;
  assign o_rx_data     = r_rx_data;
  assign o_rx_valid    = r_rx_valid;
  assign o_rx_ovf      = r_rx_ovf;
  assign o_tx_ready    = r_tx_ready;
  assign o_tx_underrun = r_tx_underrun;
  assign o_start       = r_start;
  assign o_stop        = r_stop;
  assign o_busy        = r_busy;

endmodule

// File: tb/tb_i2c_slave_sync.sv
// ---------------------------------------------------------------------------
// tb_i2c_slave_sync
// Bus-level bench: an I2C master model drives open-drain SCL/SDA; expected
// DUT strobes are queued when stimulus is issued and consumed by a monitor.
// ---------------------------------------------------------------------------
module tb_i2c_slave_sync;

  localparam int Q = 10;  // quarter SCL period in system clocks

  localparam int EV_NONE  = 0;
  localparam int EV_RXV   = 1;
  localparam int EV_OVF   = 2;
  localparam int EV_TXR   = 3;
  localparam int EV_UND   = 4;
  localparam int EV_START = 5;
  localparam int EV_STOP  = 6;

  typedef struct packed {
    int         kind;
    logic [7:0] data;
  } ev_t;

  logic       clk;
  logic       rst_n;
  logic       m_scl, m_sda;
  logic       bus_scl, bus_sda;
  logic       o_SDA_OE, o_SCL_OE;
  logic [7:0] o_rx_data;
  logic       o_rx_valid, o_rx_ovf;
  logic       i_rx_ready;
  logic [7:0] i_tx_data;
  logic       i_tx_valid;
  logic       o_tx_ready, o_tx_underrun;
  logic       o_start, o_stop, o_busy;

  int  n_tests = 0;
  int  n_fail  = 0;
  int  n_start = 0;
  logic seen_stretch = 1'b0;
  ev_t sb[$];

  assign bus_scl = m_scl & ~o_SCL_OE;
  assign bus_sda = m_sda & ~o_SDA_OE;

  i2c_slave_sync dut (
    .i_CLK         (clk),
    .i_RST_N       (rst_n),
    .i_SCL         (bus_scl),
    .i_SDA         (bus_sda),
    .o_SDA_OE      (o_SDA_OE),
    .o_SCL_OE      (o_SCL_OE),
    .o_rx_data     (o_rx_data),
    .o_rx_valid    (o_rx_valid),
    .i_rx_ready    (i_rx_ready),
    .o_rx_ovf      (o_rx_ovf),
    .i_tx_data     (i_tx_data),
    .i_tx_valid    (i_tx_valid),
    .o_tx_ready    (o_tx_ready),
    .o_tx_underrun (o_tx_underrun),
    .o_start       (o_start),
    .o_stop        (o_stop),
    .o_busy        (o_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic sb_push(input int k, input logic [7:0] d);
    ev_t e;
    e.kind = k;
    e.data = d;
    sb.push_back(e);
  endtask

  task automatic sb_pop(input int k, input logic [7:0] d);
    ev_t e;
    if (sb.size() == 0) begin
      chk("sb_unexpected_event", k, EV_NONE);
    end else begin
      e = sb.pop_front();
      chk("event_kind", k, e.kind);
      if (k == EV_RXV) chk("rx_data", {24'h0, d}, {24'h0, e.data});
    end
  endtask

  always @(negedge clk) begin
    int ns;
    ns = int'(o_rx_valid) + int'(o_rx_ovf) + int'(o_tx_ready) + int'(o_tx_underrun)
       + int'(o_start) + int'(o_stop);
    if (ns != 0) chk("strobe_exclusive", ns, 1);
    if (o_SCL_OE) seen_stretch = 1'b1;
    if (o_start) begin
      n_start++;
      sb_pop(EV_START, 8'h00);
    end
    if (o_stop)        sb_pop(EV_STOP, 8'h00);
    if (o_rx_valid)    sb_pop(EV_RXV, o_rx_data);
    if (o_rx_ovf)      sb_pop(EV_OVF, 8'h00);
    if (o_tx_ready)    sb_pop(EV_TXR, 8'h00);
    if (o_tx_underrun) sb_pop(EV_UND, 8'h00);
  end

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_scl_high();
    int n = 0;
    while (!bus_scl && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (!bus_scl) chk("scl_stuck_low", 0, 1);
  endtask

  task automatic bit_xfer(input logic b, output logic r);
    wait_clks(Q);
    m_sda = b;
    wait_clks(Q);
    m_scl = 1'b1;
    wait_scl_high();
    wait_clks(Q);
    r = bus_sda;
    wait_clks(Q);
    m_scl = 1'b0;
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) bit_xfer(d[i], r);
    bit_xfer(1'b1, ack);
  endtask

  task automatic read_byte(output logic [7:0] d);
    logic r;
    d = 8'h00;
    for (int i = 0; i < 8; i++) begin
      bit_xfer(1'b1, r);
      d = {d[6:0], r};
    end
  endtask

  task automatic start_cond();
    m_sda = 1'b1;
    m_scl = 1'b1;
    wait_clks(Q);
    m_sda = 1'b0;
    wait_clks(2 * Q);
    m_scl = 1'b0;
  endtask

  task automatic rep_start();
    wait_clks(Q);
    m_sda = 1'b1;
    wait_clks(Q);
    m_scl = 1'b1;
    wait_scl_high();
    wait_clks(Q);
    m_sda = 1'b0;
    wait_clks(Q);
    m_scl = 1'b0;
  endtask

  task automatic stop_cond();
    wait_clks(Q);
    m_sda = 1'b0;
    wait_clks(Q);
    m_scl = 1'b1;
    wait_scl_high();
    wait_clks(Q);
    m_sda = 1'b1;
    wait_clks(2 * Q);
  endtask

  function automatic logic [16:0] all_outs();
    return {o_SDA_OE, o_SCL_OE, o_rx_data, o_rx_valid, o_rx_ovf, o_tx_ready,
            o_tx_underrun, o_start, o_stop, o_busy};
  endfunction

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       ack, r;
    logic [7:0] d;
    int         starts_before;

    rst_n      = 1'b0;
    m_scl      = 1'b1;
    m_sda      = 1'b1;
    i_rx_ready = 1'b1;
    i_tx_data  = 8'h00;
    i_tx_valid = 1'b0;
    wait_clks(5);
    chk("reset_outputs", {15'h0, all_outs()}, 32'h0);
    rst_n = 1'b1;
    wait_clks(20);

    // write 0xA5, 0x3C to our address
    sb_push(EV_START, 8'h00);
    start_cond();
    write_byte({7'h47, 1'b0}, ack);
    chk("wr_addr_ack", ack, 0);
    chk("wr_busy_set", o_busy, 1);
    sb_push(EV_RXV, 8'hA5);
    write_byte(8'hA5, ack);
    chk("wr_d0_ack", ack, 0);
    sb_push(EV_RXV, 8'h3C);
    write_byte(8'h3C, ack);
    chk("wr_d1_ack", ack, 0);
    sb_push(EV_STOP, 8'h00);
    stop_cond();
    chk("wr_busy_clear", o_busy, 0);

    // foreign address: nothing driven, no strobes
    sb_push(EV_START, 8'h00);
    start_cond();
    write_byte({7'h12, 1'b0}, ack);
    chk("foreign_addr_nack", ack, 1);
    chk("foreign_busy", o_busy, 0);
    write_byte(8'h55, ack);
    chk("foreign_data_nack", ack, 1);
    chk("foreign_sda_oe", o_SDA_OE, 0);
    sb_push(EV_STOP, 8'h00);
    stop_cond();

    // read 0x81 (ACK) then 0x7E (NACK)
    i_tx_data  = 8'h81;
    i_tx_valid = 1'b1;
    sb_push(EV_START, 8'h00);
    sb_push(EV_TXR, 8'h00);
    start_cond();
    write_byte({7'h47, 1'b1}, ack);
    chk("rd_addr_ack", ack, 0);
    read_byte(d);
    chk("rd_byte0", {24'h0, d}, 32'h81);
    i_tx_data = 8'h7E;
    sb_push(EV_TXR, 8'h00);
    bit_xfer(1'b0, r);
    read_byte(d);
    chk("rd_byte1", {24'h0, d}, 32'h7E);
    bit_xfer(1'b1, r);
    wait_clks(Q);
    chk("rd_wait_no_drive", o_SDA_OE, 0);
    chk("rd_wait_busy", o_busy, 1);
    sb_push(EV_STOP, 8'h00);
    stop_cond();
    chk("rd_busy_clear", o_busy, 0);

    // RX not ready on the second byte
    sb_push(EV_START, 8'h00);
    start_cond();
    write_byte({7'h47, 1'b0}, ack);
    chk("ovf_addr_ack", ack, 0);
    sb_push(EV_RXV, 8'h11);
    write_byte(8'h11, ack);
    chk("ovf_d0_ack", ack, 0);
    i_rx_ready = 1'b0;
`ifdef I2C_SLAVE_CLK_STRETCH_EN
    sb_push(EV_RXV, 8'h22);
    fork
      begin
        wait_clks(300);
        i_rx_ready = 1'b1;
      end
    join_none
    write_byte(8'h22, ack);
    chk("stretch_d1_ack", ack, 0);
    chk("stretch_seen", seen_stretch, 1);
`else
    sb_push(EV_OVF, 8'h00);
    write_byte(8'h22, ack);
    chk("ovf_d1_nack", ack, 1);
    chk("scl_oe_never", seen_stretch, 0);
`endif
    i_rx_ready = 1'b1;
    sb_push(EV_STOP, 8'h00);
    stop_cond();

    // TX side has no data at the load point
    i_tx_valid = 1'b0;
    sb_push(EV_START, 8'h00);
    start_cond();
`ifdef I2C_SLAVE_CLK_STRETCH_EN
    sb_push(EV_TXR, 8'h00);
    write_byte({7'h47, 1'b1}, ack);
    chk("und_addr_ack", ack, 0);
    fork
      begin
        wait_clks(200);
        i_tx_data  = 8'h33;
        i_tx_valid = 1'b1;
      end
    join_none
    read_byte(d);
    chk("stretch_rd_byte", {24'h0, d}, 32'h33);
`else
    sb_push(EV_UND, 8'h00);
    write_byte({7'h47, 1'b1}, ack);
    chk("und_addr_ack", ack, 0);
    read_byte(d);
    chk("und_fill_byte", {24'h0, d}, 32'hFF);
`endif
    bit_xfer(1'b1, r);
    sb_push(EV_STOP, 8'h00);
    stop_cond();

    // 2-cycle SDA glitch while SCL high must not look like START
    starts_before = n_start;
    m_sda = 1'b0;
    wait_clks(2);
    m_sda = 1'b1;
    wait_clks(30);
    chk("glitch_no_start", n_start, starts_before);

    // repeated START in the middle of a read
    i_tx_data  = 8'hC0;
    i_tx_valid = 1'b1;
    sb_push(EV_START, 8'h00);
    sb_push(EV_TXR, 8'h00);
    start_cond();
    write_byte({7'h47, 1'b1}, ack);
    chk("rs_addr_ack", ack, 0);
    sb_push(EV_START, 8'h00);
    rep_start();
    wait_clks(Q);
    chk("rs_sda_released", o_SDA_OE, 0);
    chk("rs_busy_clear", o_busy, 0);
    write_byte({7'h47, 1'b0}, ack);
    chk("rs_readdr_ack", ack, 0);
    chk("rs_busy_set", o_busy, 1);
    sb_push(EV_STOP, 8'h00);
    stop_cond();

    // reset while the slave is pulling SDA low for the address ACK
    sb_push(EV_START, 8'h00);
    start_cond();
    d = {7'h47, 1'b1};
    for (int i = 7; i >= 0; i--) bit_xfer(d[i], r);
    wait_clks(Q);
    chk("pre_reset_drive", o_SDA_OE, 1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_reset_outputs", {15'h0, all_outs()}, 32'h0);
    m_sda = 1'b1;
    m_scl = 1'b1;
    wait_clks(4);
    rst_n = 1'b1;
    wait_clks(20);
    sb_push(EV_START, 8'h00);
    start_cond();
    write_byte({7'h47, 1'b0}, ack);
    chk("post_reset_addr_ack", ack, 0);
    sb_push(EV_RXV, 8'h5A);
    write_byte(8'h5A, ack);
    chk("post_reset_d_ack", ack, 0);
    sb_push(EV_STOP, 8'h00);
    stop_cond();

    wait_clks(50);
    chk("scoreboard_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
